// File: rtl/tt_um_carry_lookahead_adder.sv
// -----------------------------------------------------------------------------
// tt_um_carry_lookahead_adder
//
// 7-bit two-level carry-lookahead adder with a registered 8-bit result.
// It computes {COUT, SUM} = A + B' + C. Bits [3:0] form lookahead group 0 and
// bits [6:4] form group 1. A second-level unit combines the group
// propagate/generate terms into c4 and COUT.
//
// Optional feature:
//   CLA_SUB_EN  - when defined, uio_in[7]=1 selects subtract mode:
//                 B' = ~B and C = 1, and CIN is ignored. COUT=1 means no borrow.
//                 When undefined, uio_in[7] is ignored and no subtract logic
//                 exists.
//
// Ports:
//   clk      in   1  clock; all state updates on its rising edge
//   rst_n    in   1  synchronous reset, ACTIVE-HIGH (1 = reset); the name is
//                    kept for harness compatibility
//   ena      in   1  1 = output register loads, 0 = output register holds
//   ui_in    in   8  [6:0] operand A, [7] carry-in CIN
//   uio_in   in   8  [6:0] operand B, [7] SUB select (CLA_SUB_EN builds only)
//   uo_out   out  8  registered result: [6:0] SUM, [7] COUT
//   uio_out  out  8  constant 0x00
//   uio_oe   out  8  constant 0x00 (all uio pins are inputs)
// -----------------------------------------------------------------------------
module tt_um_carry_lookahead_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [6:0] a;
    logic [6:0] b_eff;
    logic       c_in;
    logic [6:0] p;
    logic [6:0] g;
    logic [6:0] c;        // c[i] is the carry into bit i
    logic       pg0, gg0; // group 0 (bits [3:0])
    logic       pg1, gg1; // group 1 (bits [6:4])
    logic       c4;
    logic       cout;
    logic [6:0] sum;
    logic [7:0] result_d;
    logic [7:0] result_q;

    // Operand conditioning: select B' and the carry-in C.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first. A
        // path that leaves a signal unassigned would infer a latch.
        a     = ui_in[6:0];
        b_eff = uio_in[6:0];
        c_in  = ui_in[7];
`ifdef CLA_SUB_EN
        if (uio_in[7]) begin
            b_eff = ~uio_in[6:0];
            c_in  = 1'b1;
        end
`endif
    end

`ifndef CLA_SUB_EN
    // The SUB select is intentionally unused when subtract mode is compiled out.
    logic unused_sub_sel;
    assign unused_sub_sel = uio_in[7];
`endif

    assign p = a ^ b_eff;
    assign g = a & b_eff;

    // Two-level lookahead. Every carry is a flat sum of products of p, g and
    // the carry into its group. No carry is built from the previous carry.
    always_comb begin
        // Group 0 internal carries.
        c[0] = c_in;
        c[1] = g[0] | (p[0] & c_in);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_in);

        // Group terms.
        pg0 = &p[3:0];
        gg0 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
        pg1 = &p[6:4];
        gg1 = g[6] | (p[6] & g[5]) | (p[6] & p[5] & g[4]);

        // Second-level lookahead unit.
        c4   = gg0 | (pg0 & c_in);
        cout = gg1 | (pg1 & c4);

        // Group 1 internal carries, taken from c4 produced by the second level.
        c[4] = c4;
        c[5] = g[4] | (p[4] & c4);
        c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c4);

        sum = p ^ c;
    end

    // Output register next state. Reset has priority and is applied in the flop.
    always_comb begin
        result_d = result_q;
        if (ena) begin
            result_d = {cout, sum};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. This keeps
    // the update order independent of how the always blocks are scheduled.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            result_q <= 8'h00;
        end else begin
            result_q <= result_d;
        end
    end

    assign uo_out  = result_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_carry_lookahead_adder.sv
// -----------------------------------------------------------------------------
// Testbench for tt_um_carry_lookahead_adder.
//
// The driver applies inputs on the falling edge. For each cycle it pushes the
// uo_out value expected after the next rising edge into a queue. The monitor
// pops one entry 1 ns after each rising edge and compares it with uo_out.
// The monitor also checks that uio_out and uio_oe stay at 0x00.
//
// Expected values come from fixed vectors or from an arithmetic reference
// model: the integer sum A + B' + C.
// -----------------------------------------------------------------------------
module tb_tt_um_carry_lookahead_adder;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int unsigned checks;
    int unsigned errors;
    logic [7:0]  exp_q[$];
    logic [7:0]  model_q;   // reference copy of the output register

    tt_um_carry_lookahead_adder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operand fields.
    function automatic logic [7:0] ref_add(input logic [7:0] ui, input logic [7:0] uio);
        int a_v, b_v, c_v, total;
        a_v = int'(ui[6:0]);
        b_v = int'(uio[6:0]);
        c_v = int'(ui[7]);
`ifdef CLA_SUB_EN
        if (uio[7]) begin
            b_v = 127 - b_v;   // 7-bit ones' complement
            c_v = 1;
        end
`endif
        total = a_v + b_v + c_v;
        return total[7:0];
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Directed cycle: the expected value is a fixed constant.
    task automatic drive_exp(input logic rst, input logic en, input logic [7:0] ui,
                             input logic [7:0] uio, input logic [7:0] expv);
        @(negedge clk);
        rst_n  = rst;
        ena    = en;
        ui_in  = ui;
        uio_in = uio;
        model_q = expv;
        exp_q.push_back(expv);
    endtask

    // Modelled cycle: the expected value comes from the reference model.
    task automatic drive_model(input logic rst, input logic en, input logic [7:0] ui,
                               input logic [7:0] uio);
        @(negedge clk);
        rst_n  = rst;
        ena    = en;
        ui_in  = ui;
        uio_in = uio;
        if (rst)     model_q = 8'h00;
        else if (en) model_q = ref_add(ui, uio);
        exp_q.push_back(model_q);
    endtask

    // Monitor: one result per rising edge whenever an expectation is pending.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                check("uo_out", uo_out, exp_q.pop_front());
                check("uio_out", uio_out, 8'h00);
                check("uio_oe", uio_oe, 8'h00);
            end
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        model_q = 8'h00;
        rst_n   = 1'b1;
        ena     = 1'b0;
        ui_in   = 8'h00;
        uio_in  = 8'h00;

        // Reset held for 2 cycles with live inputs and ena=1.
        drive_exp(1'b1, 1'b1, 8'h7F, 8'h7F, 8'h00);
        drive_exp(1'b1, 1'b1, 8'h7F, 8'h7F, 8'h00);

        // Group-boundary carry c4.
        drive_exp(1'b0, 1'b1, 8'h0F, 8'h00, 8'h0F);
        drive_exp(1'b0, 1'b1, 8'h8F, 8'h00, 8'h10);

        // Full carry chain and wrap-around.
        drive_exp(1'b0, 1'b1, 8'h7F, 8'h01, 8'h80);
        drive_exp(1'b0, 1'b1, 8'hFF, 8'h7F, 8'hFF);

        // Hold with ena=0 while the inputs change.
        drive_exp(1'b0, 1'b1, 8'h12, 8'h34, 8'h46);
        for (int i = 0; i < 3; i++) drive_exp(1'b0, 1'b0, 8'h7F, 8'h7F, 8'h46);

        // Reset during operation discards the pending result; next result follows 1 cycle later.
        drive_exp(1'b1, 1'b1, 8'h12, 8'h34, 8'h00);
        drive_exp(1'b0, 1'b1, 8'h05, 8'h06, 8'h0B);

        // Reset beats ena while holding; reset with ena=0 still clears.
        drive_exp(1'b1, 1'b0, 8'h7F, 8'h7F, 8'h00);

`ifdef CLA_SUB_EN
        drive_exp(1'b0, 1'b1, 8'h05, 8'h83, 8'h82);
        drive_exp(1'b0, 1'b1, 8'h03, 8'h85, 8'h7E);
`else
        // Without subtract mode, uio_in[7] is ignored.
        drive_exp(1'b0, 1'b1, 8'h05, 8'h83, 8'h08);
        drive_exp(1'b0, 1'b1, 8'h83, 8'h85, 8'h09);
`endif

        // Random operands, ena=1.
        for (int i = 0; i < 10000; i++) begin
            drive_model(1'b0, 1'b1, 8'($urandom), 8'($urandom));
        end

        // Random mix of reset, enable and operands.
        for (int i = 0; i < 500; i++) begin
            drive_model(($urandom_range(15) == 0), ($urandom_range(3) != 0),
                        8'($urandom), 8'($urandom));
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
